// File: rtl/sram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sram_fifo_pkg
// Shared sizing constants, types and helpers for the SRAM-backed FIFO
// controller (sram_fifo_ctrl) and its output buffer (sram_fifo_outbuf).
//   DEPTH  : SRAM entries (power of two, matches the sram8t128x72 macro)
//   WIDTH  : data word width (matches the macro)
//   ADDR_W : SRAM address width
//   CNT_W  : total occupancy counter width (DEPTH words + 2 buffered)
// -----------------------------------------------------------------------------
package sram_fifo_pkg;

    localparam int unsigned DEPTH    = 128;
    localparam int unsigned WIDTH    = 72;
    localparam int unsigned ADDR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 3);
    localparam int unsigned OB_DEPTH = 2;
    localparam int unsigned OB_CNT_W = 2;

    typedef logic [WIDTH-1:0]    word_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [OB_CNT_W-1:0] ob_cnt_t;

    // True when the output buffer can absorb one more word next cycle, given
    // its occupancy, a read landing this cycle, and a pop this cycle:
    // occ + pend - deq < OB_DEPTH, rearranged to stay unsigned.
    function automatic logic ob_has_room(input ob_cnt_t occ,
                                         input logic    pend,
                                         input logic    deq);
        logic [2:0] w_lhs;
        logic [2:0] w_rhs;
        w_lhs = 3'(occ) + 3'(pend);
        w_rhs = 3'(OB_DEPTH) + 3'(deq);
        return (w_lhs < w_rhs);
    endfunction

endpackage : sram_fifo_pkg

// File: rtl/sram_fifo_outbuf.sv
// -----------------------------------------------------------------------------
// sram_fifo_outbuf
// Two-entry in-order output buffer that hides the SRAM read latency.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   i_clear        : synchronous flush
//   i_push         : write i_push_data at the tail (caller guarantees room)
//   i_push_data    : word to append
//   i_pop          : consumer takes the head (ignored while empty)
//   o_valid        : head entry present
//   o_data         : head entry
//   o_cnt          : occupancy (0..2)
// -----------------------------------------------------------------------------
module sram_fifo_outbuf
    import sram_fifo_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    i_clear,
    input  logic    i_push,
    input  word_t   i_push_data,
    input  logic    i_pop,
    output logic    o_valid,
    output word_t   o_data,
    output ob_cnt_t o_cnt
);

    word_t   r_d0;      // head
    word_t   r_d1;      // second entry
    ob_cnt_t r_cnt;
    logic    r_valid;
    logic    w_pop;

    assign w_pop = i_pop & r_valid;

    // Storage and occupancy update; push lands in the first free slot
    // after the pop has been applied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d0    <= '0;
            r_d1    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case ({w_pop, i_push})
                2'b10: begin
                    r_d0    <= r_d1;
                    r_cnt   <= r_cnt - OB_CNT_W'(1);
                    r_valid <= (r_cnt == OB_CNT_W'(2));
                end
                2'b01: begin
                    if (r_cnt == '0) begin
                        r_d0 <= i_push_data;
                    end else begin
                        r_d1 <= i_push_data;
                    end
                    r_cnt   <= r_cnt + OB_CNT_W'(1);
                    r_valid <= 1'b1;
                end
                2'b11: begin
                    if (r_cnt == OB_CNT_W'(1)) begin
                        r_d0 <= i_push_data;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_d0;
    assign o_cnt   = r_cnt;

endmodule : sram_fifo_outbuf

// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
// Sequences the sram8t128x72 dual-port macro (port 1 read, port 2 write,
// registered 1-cycle read) as a DEPTH x WIDTH queue with valid/ready on both
// sides. A 2-entry output buffer keeps dequeue at one word per cycle.
// Macro CE1/CE2 are tied to clk at the level above.
//
// Optional build macro SRAM_FIFO_BYPASS_EN: when the SRAM and the read
// pipeline are empty and the output buffer has room, an enqueued word goes
// straight into the output buffer (1-cycle latency instead of 3).
//
// Ports:
//   clk, reset_n           : clock, async active-low reset
//   clear                  : synchronous flush pulse
//   in_valid/in_ready/in_data    : producer side
//   out_valid/out_ready/out_data : consumer side
//   count                  : words held (SRAM + in-flight read + out buffer)
//   sram_a1/csb1/oeb1/o1   : macro read port
//   sram_a2/csb2/web2/i2   : macro write port
// -----------------------------------------------------------------------------
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  clear,
    input  logic  in_valid,
    output logic  in_ready,
    input  word_t in_data,
    output logic  out_valid,
    input  logic  out_ready,
    output word_t out_data,
    output cnt_t  count,
    output addr_t sram_a1,
    output logic  sram_csb1,
    output logic  sram_oeb1,
    input  word_t sram_o1,
    output addr_t sram_a2,
    output logic  sram_csb2,
    output logic  sram_web2,
    output word_t sram_i2
);

    addr_t   r_wr_ptr;
    addr_t   r_rd_ptr;
    cnt_t    r_sram_cnt;
    cnt_t    r_count;
    logic    r_rd_pending;

    logic    w_enq;
    logic    w_deq;
    logic    w_rd_issue;
    logic    w_bypass;
    logic    w_sram_wr;
    logic    w_ob_push;
    word_t   w_ob_data;
    logic    w_ob_valid;
    word_t   w_ob_head;
    ob_cnt_t w_ob_cnt;

    // Handshakes; in_ready depends only on registered SRAM occupancy.
    assign in_ready = (r_sram_cnt != CNT_W'(DEPTH));
    assign w_enq    = in_valid & in_ready;
    assign w_deq    = w_ob_valid & out_ready;

    // Read only words committed at an earlier edge, and only when the output
    // buffer is guaranteed a slot when the data returns next cycle.
    assign w_rd_issue = (r_sram_cnt != '0) &&
                        ob_has_room(w_ob_cnt, r_rd_pending, w_deq);

`ifdef SRAM_FIFO_BYPASS_EN
    // Nothing older than this word exists outside the out buffer, so writing
    // it there directly keeps order.
    assign w_bypass = w_enq && (r_sram_cnt == '0) && !r_rd_pending &&
                      ob_has_room(w_ob_cnt, 1'b0, w_deq);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_sram_wr = w_enq & ~w_bypass;

    // Macro pins
    assign sram_a2   = r_wr_ptr;
    assign sram_i2   = in_data;
    assign sram_csb2 = ~w_sram_wr;
    assign sram_web2 = ~w_sram_wr;
    assign sram_a1   = r_rd_ptr;
    assign sram_csb1 = ~w_rd_issue;
    assign sram_oeb1 = 1'b0;

    // Returning read data has priority; bypass cannot coincide with it.
    assign w_ob_push = r_rd_pending | w_bypass;
    assign w_ob_data = r_rd_pending ? sram_o1 : in_data;

    // Pointers, occupancy counters and read pipeline flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_sram_cnt   <= '0;
            r_count      <= '0;
            r_rd_pending <= 1'b0;
        end else if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_sram_cnt   <= '0;
            r_count      <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            r_wr_ptr     <= r_wr_ptr + ADDR_W'(w_sram_wr);
            r_rd_ptr     <= r_rd_ptr + ADDR_W'(w_rd_issue);
            r_sram_cnt   <= r_sram_cnt + CNT_W'(w_sram_wr) - CNT_W'(w_rd_issue);
            r_count      <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
            r_rd_pending <= w_rd_issue;
        end
    end

    sram_fifo_outbuf u_outbuf (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (clear),
        .i_push      (w_ob_push),
        .i_push_data (w_ob_data),
        .i_pop       (w_deq),
        .o_valid     (w_ob_valid),
        .o_data      (w_ob_head),
        .o_cnt       (w_ob_cnt)
    );

    assign out_valid = w_ob_valid;
    assign out_data  = w_ob_head;
    assign count     = r_count;

endmodule : sram_fifo_ctrl

// File: tb/tb_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_ctrl
// Bench for sram_fifo_ctrl with a behavioural model of the sram8t128x72 macro.
// The reference is a plain word queue: count must equal its size, the head
// must match its front, and in_ready follows from its occupancy.
// Build with SRAM_FIFO_BYPASS_EN to check the bypass variant.
// -----------------------------------------------------------------------------
module tb_sram_fifo_ctrl;
    import sram_fifo_pkg::*;

    logic  clk;
    logic  reset_n;
    logic  clear;
    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;
    cnt_t  count;
    addr_t sram_a1;
    logic  sram_csb1;
    logic  sram_oeb1;
    word_t sram_o1;
    addr_t sram_a2;
    logic  sram_csb2;
    logic  sram_web2;
    word_t sram_i2;

    sram_fifo_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .sram_a1   (sram_a1),
        .sram_csb1 (sram_csb1),
        .sram_oeb1 (sram_oeb1),
        .sram_o1   (sram_o1),
        .sram_a2   (sram_a2),
        .sram_csb2 (sram_csb2),
        .sram_web2 (sram_web2),
        .sram_i2   (sram_i2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: write and registered read on the same edge; read sees old data.
    word_t mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_csb2 && !sram_web2) mem[sram_a2] <= sram_i2;
        if (!sram_csb1) sram_o1 <= mem[sram_a1];
    end

    int    checks = 0;
    int    errors = 0;
    int    cyc_n  = 0;
    int    gap    = 0;
    word_t q[$];
    word_t dummy;

    logic  s_in_ready, s_out_valid, s_csb1, s_csb2, s_web2, s_enq, s_deq;
    word_t s_out_data;
    cnt_t  s_count;
    addr_t s_a1, s_a2;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample and check at negedge, update the model at posedge.
    task automatic cyc();
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_data  = out_data;
        s_count     = count;
        s_csb1      = sram_csb1;
        s_csb2      = sram_csb2;
        s_web2      = sram_web2;
        s_a1        = sram_a1;
        s_a2        = sram_a2;
        s_enq       = in_valid & in_ready;
        s_deq       = out_valid & out_ready;
        check("count", 72'(s_count), 72'(q.size()));
        check("count_max", 72'(s_count <= 8'd130), 72'(1));
        if (q.size() == 0) begin
            check("valid_when_empty", 72'(s_out_valid), 72'(0));
            gap = 0;
        end else if (s_out_valid) begin
            check("head_data", s_out_data, q[0]);
            gap = 0;
        end else begin
            gap++;
            check("out_gap", 72'(gap <= 2), 72'(1));
        end
        if (q.size() < 128) check("in_ready_open", 72'(s_in_ready), 72'(1));
        else if (q.size() == 130) check("in_ready_full", 72'(s_in_ready), 72'(0));
        check("rw_hazard", 72'(!s_csb1 && !s_csb2 && (s_a1 == s_a2)), 72'(0));
        @(posedge clk);
        if (clear) begin
            q.delete();
        end else begin
            if (s_deq && q.size() > 0) dummy = q.pop_front();
            if (s_enq) q.push_back(in_data);
        end
        cyc_n++;
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 600 && q.size() != 0; i++) cyc();
        check("drain_done", 72'(q.size()), 72'(0));
    endtask

    initial begin
        int sent, accepted, first_deq, last_deq, ndeq;
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 72'(count), 72'(0));
        check("rst_out_valid", 72'(out_valid), 72'(0));
        check("rst_in_ready", 72'(in_ready), 72'(1));
        check("rst_csb1", 72'(sram_csb1), 72'(1));
        check("rst_csb2", 72'(sram_csb2), 72'(1));
        check("rst_web2", 72'(sram_web2), 72'(1));
        check("rst_a1", 72'(sram_a1), 72'(0));
        check("rst_a2", 72'(sram_a2), 72'(0));
        reset_n = 1'b1;

        // Single word latency
        in_valid = 1'b1; in_data = 72'h1; out_ready = 1'b1;
        cyc();
`ifdef SRAM_FIFO_BYPASS_EN
        check("lat_csb2_bypass", 72'(s_csb2), 72'(1));
        in_valid = 1'b0;
        cyc();
        check("lat_out_valid", 72'(s_out_valid), 72'(1));
        check("lat_out_data", s_out_data, 72'h1);
        cyc();
        check("lat_count_after", 72'(s_count), 72'(0));
`else
        check("lat_csb2", 72'(s_csb2), 72'(0));
        check("lat_web2", 72'(s_web2), 72'(0));
        check("lat_a2", 72'(s_a2), 72'(0));
        in_valid = 1'b0;
        cyc();
        check("lat_csb1", 72'(s_csb1), 72'(0));
        check("lat_a1", 72'(s_a1), 72'(0));
        cyc();
        check("lat_not_yet", 72'(s_out_valid), 72'(0));
        cyc();
        check("lat_out_valid", 72'(s_out_valid), 72'(1));
        check("lat_out_data", s_out_data, 72'h1);
        check("lat_count_one", 72'(s_count), 72'(1));
        cyc();
        check("lat_count_after", 72'(s_count), 72'(0));
`endif

        // Streaming 300 words
        sent = 0; first_deq = -1; last_deq = 0; ndeq = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 400 && (sent < 300 || q.size() != 0); i++) begin
            in_valid = (sent < 300);
            in_data  = 72'(sent);
            cyc();
            if (s_enq) sent++;
            if (s_deq) begin
                if (first_deq < 0) first_deq = cyc_n;
                last_deq = cyc_n;
                ndeq++;
            end
        end
        check("stream_deq_count", 72'(ndeq), 72'(300));
        check("stream_no_gaps", 72'(last_deq - first_deq), 72'(299));

        // Fill to capacity
        accepted = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            in_data  = 72'(32'hF000_0000 + 32'(i));
            cyc();
            if (s_enq) accepted++;
            if (!s_in_ready) break;
        end
        check("fill_accepted", 72'(accepted), 72'(130));
        check("fill_count", 72'(s_count), 72'(130));
        check("fill_in_ready", 72'(s_in_ready), 72'(0));
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        cyc();
        check("pulse_count", 72'(s_count), 72'(129));
        check("pulse_in_ready", 72'(s_in_ready), 72'(1));
        drain();

        // Random traffic
        sent = 0;
        for (int i = 0; i < 60000 && sent < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 72'({$urandom(), $urandom(), $urandom()});
            cyc();
            if (s_enq) sent++;
        end
        check("random_sent", 72'(sent), 72'(10000));
        drain();

        // Clear with a read in flight
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 72'(16'h100 + 16'(k));
            cyc();
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 72'h105;
        cyc();
        check("clr_read_issued", 72'(s_csb1), 72'(0));
        check("clr_count_pre", 72'(s_count), 72'(5));
        out_ready = 1'b0; in_valid = 1'b1; in_data = 72'hBB; clear = 1'b1;
        cyc();
        check("clr_count_at", 72'(s_count), 72'(5));
        clear = 1'b0; in_valid = 1'b1; in_data = 72'hAA;
        cyc();
        check("clr_count_zero", 72'(s_count), 72'(0));
        check("clr_out_valid", 72'(s_out_valid), 72'(0));
        check("clr_in_ready", 72'(s_in_ready), 72'(1));
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (s_deq) break;
        end
        check("clr_next_deq", 72'(s_deq), 72'(1));
        check("clr_next_word", s_out_data, 72'hAA);
        drain();

        // Bypass path into an empty FIFO
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 72'hA1;
        cyc();
`ifdef SRAM_FIFO_BYPASS_EN
        check("byp_first_csb2", 72'(s_csb2), 72'(1));
        in_data = 72'hA2;
        cyc();
        check("byp_out_valid", 72'(s_out_valid), 72'(1));
        check("byp_second_csb2", 72'(s_csb2), 72'(1));
        in_data = 72'hA3;
        cyc();
        check("byp_third_csb2", 72'(s_csb2), 72'(0));
`else
        check("nobyp_first_csb2", 72'(s_csb2), 72'(0));
        in_valid = 1'b0;
        cyc();
        check("nobyp_out_valid", 72'(s_out_valid), 72'(0));
`endif
        drain();

        // Async reset mid-operation
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 72'(16'h300 + 16'(k));
            cyc();
        end
        in_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        check("arst_count", 72'(count), 72'(0));
        check("arst_out_valid", 72'(out_valid), 72'(0));
        check("arst_in_ready", 72'(in_ready), 72'(1));
        check("arst_csb1", 72'(sram_csb1), 72'(1));
        q.delete();
        gap = 0;
        #1;
        reset_n = 1'b1;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sram_fifo_ctrl

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- FIFO controller that sequences the sram8t128x72 dual-port macro (port 1 read-only, port 2 write-only, 1-cycle registered read) as a 128-deep x 72-bit queue with valid/ready on both sides.
- Hides macro read latency with a 2-entry output buffer, so dequeue sustains 1 word/cycle.
- Sits between a producer and a consumer; the top level ties macro CE1 and CE2 to clk.

Parameters:
- DEPTH, 128, SRAM entries; power of two, must match macro.
- WIDTH, 72, data width; must match macro.
- ADDR_W, $clog2(DEPTH) = 7, SRAM address width.
- CNT_W, $clog2(DEPTH+3) = 8, occupancy counter width.

Ports:
- clk  in  1  single clock; also drives macro CE1/CE2.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, one-cycle pulse.
- in_valid  in  1  producer has data.
- in_ready  out  1  controller accepts data.
- in_data  in  WIDTH  enqueue data.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes head.
- out_data  out  WIDTH  head word.
- count  out  CNT_W  total words held (SRAM + in-flight + out buffer).
- sram_a1  out  ADDR_W  read address.
- sram_csb1  out  1  read chip select, active-low.
- sram_oeb1  out  1  output enable; tied 0.
- sram_o1  in  WIDTH  macro read data, valid the cycle after the read is issued.
- sram_a2  out  ADDR_W  write address.
- sram_csb2  out  1  write chip select, active-low.
- sram_web2  out  1  write enable, active-low.
- sram_i2  out  WIDTH  write data.

Behaviour:
- Reset values (async, reset_n=0):
  - wr_ptr = rd_ptr = 0; sram_cnt = 0; rd_pending = 0; out buffer empty.
  - out_valid = 0; count = 0; in_ready = 1.
  - sram_csb1 = sram_csb2 = sram_web2 = 1; addresses 0.
- Enqueue (enq = in_valid & in_ready):
  - in_ready = (sram_cnt != DEPTH), from registered state only; no path from out_ready.
  - On enq: sram_csb2 = sram_web2 = 0, sram_a2 = wr_ptr, sram_i2 = in_data, all combinational.
  - wr_ptr increments mod DEPTH at the edge.
- Read issue (rd_issue) when all of the following hold; drive sram_csb1 = 0, sram_a1 = rd_ptr:
  - sram_cnt > 0 (registered, so a word written at edge N is never read before edge N+1; no same-edge read/write hazard);
  - out_cnt + rd_pending - deq < 2, where deq = out_valid & out_ready.
- Read capture:
  - rd_pending <= rd_issue.
  - When rd_pending = 1, sram_o1 is pushed into the out buffer that cycle.
- Counters:
  - sram_cnt += enq - rd_issue.
  - count += enq - deq.
  - Simultaneous enq/deq/rd_issue resolve independently.
- Out buffer: 2-entry in-order; out_valid = out_cnt != 0; out_data = head entry.
- Latency, enqueue to out_valid, empty FIFO: 3 cycles (write edge, read edge, capture edge).
- Throughput: 1 enq and 1 deq per cycle sustained.
- Capacity: DEPTH words in SRAM plus 2 in the out buffer, so count max = DEPTH+2 = 130.
- Full: in_valid held with in_ready = 0 produces no write and no pointer change.
- Empty: out_valid = 0; out_ready is ignored.
- Wrap-around: pointers roll 127 -> 0; sram_cnt disambiguates full from empty.
- clear:
  - Next edge sets pointers, counters, rd_pending and the out buffer to 0.
  - An in-flight read is discarded.
  - An enq in the same cycle as clear is dropped; in_ready stays 1.
  - The macro write for that cycle still occurs, but the entry is unreachable.
- Async reset mid-operation: immediate return to reset values; SRAM contents are don't-care.

Optional Feature:
- Macro: SRAM_FIFO_BYPASS_EN.
- When defined: if sram_cnt = 0, rd_pending = 0, and out_cnt - deq < 2, enq writes in_data directly into the out buffer, bypassing the SRAM (no csb2 assertion). Enqueue-to-out_valid latency drops to 1 cycle. Ordering is preserved.
- When undefined: all data passes through the SRAM; latency is 3 cycles.

Decomposition:
- Package sram_fifo_pkg holds:
  - DEPTH, WIDTH, ADDR_W, CNT_W;
  - typedef word_t (logic [WIDTH-1:0]), addr_t, cnt_t.
- Sub-module sram_fifo_outbuf: 2-entry valid/ready buffer with push/pop, head data, out_cnt. The top level owns pointers, counters, issue logic and macro pins.

Test Plan:
- Reset, then enqueue 0x1 in cycle 0 with out_ready = 1 -> sram_csb2/web2 low, a2 = 0 in cycle 0; csb1 low, a1 = 0 in cycle 1; out_valid = 1 with out_data = 0x1 in cycle 3; count 1 -> 0.
- Stream 300 words 0..299 with in_valid = out_ready = 1 -> after startup, one word out per cycle, in order, no gaps; pointers wrap twice.
- Fill with out_ready = 0 -> in_ready drops after 130 accepted words (count = 130, sram_cnt = 128); then a 1-cycle out_ready pulse -> count 129, in_ready = 1 the following cycle.
- Random in_valid/out_ready at 50% over 10k words -> scoreboard order/data match; count never exceeds 130; no read of an address written the same cycle.
- Pulse clear with rd_pending = 1 and count = 5 -> next cycle count = 0, out_valid = 0; the next enqueued 0xAA is the next word out.
- With SRAM_FIFO_BYPASS_EN, enqueue into an empty FIFO -> out_valid the next cycle, sram_csb2 stays 1; a second back-to-back word also bypasses; a third goes to the SRAM; order is preserved.
